cfg_lbus_initiator: RTL
=======================

Name: cfg_lbus_initiator

Overview:
- Command-side master for the local configuration bus; drives write/read strobes into a configuration endpoint (CPE) and collects the endpoint's read-return beats.
- Upstream: single-outstanding request/response handshake from the host/CPU config path.
- Downstream: local-bus command outputs plus the CPE return channel.
- Provides address matching on returns, a read timeout and a stray-return indication.

Parameters:
- ADDR_W, 19, local-bus address width
- DATA_W, 32, local-bus data width
- TIMEOUT_CYCLES, 64, cycles to wait for a read return before giving up; valid range 2..65535
- TMO_W, 16, width of the timeout counter

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  upstream request valid
- o_req_ready  out  1  initiator can accept a request
- i_req_wr  in  1  1 = write, 0 = read
- iv_req_addr  in  ADDR_W  request address
- i_req_addr_fixed  in  1  fixed-address (register/table) access flag
- iv_req_wdata  in  DATA_W  write data
- o_rsp_valid  out  1  one-cycle completion pulse
- ov_rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- o_rsp_timeout  out  1  qualifies o_rsp_valid: read timed out
- o_wr  out  1  local-bus write strobe
- o_rd  out  1  local-bus read strobe
- ov_addr  out  ADDR_W  local-bus address
- o_addr_fixed  out  1  local-bus fixed-address flag
- ov_wdata  out  DATA_W  local-bus write data
- i_wr  in  1  return beat valid from endpoint
- iv_addr  in  ADDR_W  return beat address
- i_addr_fixed  in  1  return beat fixed flag
- iv_rdata  in  DATA_W  return beat data
- o_stray  out  1  one-cycle pulse: unmatched or unexpected return beat

Behaviour:
- Reset: one clock, synchronous, active-high (i_rst). State=IDLE. Every output is 0 except o_req_ready, which is 1 (IDLE). The latched request is cleared and the timer is 0.
- Reset mid-operation: abandons the transaction and issues no o_rsp_valid. A return that arrives later in IDLE raises o_stray.
- FSM states: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid & o_req_ready, latch wr, addr, fixed and wdata, then go to ISSUE.
- ISSUE (exactly one cycle):
  - Drive the latched addr, fixed flag and wdata onto ov_addr, o_addr_fixed and ov_wdata.
  - Pulse o_wr (write) or o_rd (read); the two are never high together.
  - Write goes to DONE. Read goes to WAIT_RSP with timer=0.
  - Outside ISSUE, ov_addr, o_addr_fixed and ov_wdata are 0.
- WAIT_RSP:
  - Match condition: i_wr & i_addr_fixed & (iv_addr == latched addr). On match, capture iv_rdata and go to DONE with timeout=0.
  - A return beat that fails the match raises o_stray. It does not affect the timer.
  - Otherwise the timer increments. When timer == TIMEOUT_CYCLES-1 with no match, go to DONE with timeout=1 and rdata=0.
  - A match and timer expiry in the same cycle: the match wins.
- DONE (one cycle):
  - o_rsp_valid=1; ov_rsp_rdata and o_rsp_timeout are valid.
  - Return to IDLE.
  - ov_rsp_rdata and o_rsp_timeout are 0 whenever o_rsp_valid=0.
- Any return beat in IDLE, ISSUE or DONE raises o_stray and is dropped.
- Latency, with the request accepted at cycle 0:
  - Write: o_wr at cycle 1, o_rsp_valid at cycle 2.
  - Read: o_rd at cycle 1. With a return arriving at cycle 1+L, o_rsp_valid is at cycle 2+L.
  - Next accept: earliest on the cycle after DONE.
- Single outstanding transaction; no request queuing. i_req_valid held while o_req_ready=0 is simply not accepted.
- Registered outputs: all outputs come from flops except o_req_ready (decoded from state) and o_stray (registered one cycle after the offending beat).

Decomposition:
- Shared package cfg_lbus_pkg holds:
  - ADDR_W and DATA_W
  - state encoding localparams IDLE, ISSUE, WAIT_RSP, DONE
  - the return-match function (valid, fixed, address equality)
- One natural sub-module: cfg_lbus_timeout_cnt (clear, enable, expire at TIMEOUT_CYCLES-1).
- Everything else stays in a single module.

Test Plan:
- Write: req wr=1, addr=0x00010, fixed=1, wdata=0x0000ABCD -> o_wr=1, ov_addr=0x00010, ov_wdata=0x0000ABCD at cycle 1; o_rsp_valid=1, rdata=0, timeout=0 at cycle 2.
- Read with 5-cycle endpoint: req rd addr=0x003FF -> o_rd at cycle 1; return addr=0x003FF, fixed=1, rdata=0x00001234 at cycle 6 -> o_rsp_valid at cycle 7, rdata=0x00001234, timeout=0.
- Timeout: read addr=0x00800 (endpoint ignores it), TIMEOUT_CYCLES=64 -> o_rsp_valid with timeout=1, rdata=0, exactly 65 cycles after o_rd; no o_stray.
- Stray/mismatch: during WAIT_RSP inject return addr=0x00005 while expecting 0x00006 -> o_stray pulse, still waiting; matching beat later completes normally. Also inject a return beat in IDLE -> o_stray pulse only.
- Simultaneous: matching return on the expiry cycle -> timeout=0 with captured data. Back-to-back requests with i_req_valid held high -> second accepted the cycle after o_rsp_valid.
- Reset mid-read: assert i_rst in WAIT_RSP -> next cycle all outputs 0 and o_req_ready=1, no o_rsp_valid; the late return raises o_stray.

Source files
------------

// File: rtl/cfg_lbus_pkg.sv
// Shared widths, FSM encoding, request payload and return-match rule for the
// local configuration bus initiator.
package cfg_lbus_pkg;

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ISSUE    = 2'd1;
  localparam logic [STATE_W-1:0] WAIT_RSP = 2'd2;
  localparam logic [STATE_W-1:0] DONE     = 2'd3;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              fixed;
    logic [DATA_W-1:0] wdata;
  } lbus_req_t;

  // A return beat belongs to the outstanding read only if it is a valid,
  // fixed-address beat carrying the same address that was issued.
  function automatic logic ret_match(input logic              valid,
                                     input logic              fixed,
                                     input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] exp_addr);
    return valid & fixed & (addr == exp_addr);
  endfunction

endpackage

// File: rtl/cfg_lbus_timeout_cnt.sv
// Read-return watchdog: counts enabled cycles from a clear and flags the
// cycle on which the count reaches TIMEOUT_CYCLES-1.
module cfg_lbus_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMO_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire_c
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] cnt;

  // Saturates at LAST so a held enable never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en && !expire_c) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expire_c = (cnt == LAST);

endmodule

// File: rtl/cfg_lbus_initiator.sv
// Single-outstanding command master for the local configuration bus: issues
// one write/read strobe, collects the matching read return, times out reads.
module cfg_lbus_initiator
  import cfg_lbus_pkg::*;
#(
  parameter int unsigned ADDR_W         = cfg_lbus_pkg::ADDR_W,
  parameter int unsigned DATA_W         = cfg_lbus_pkg::DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMO_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] iv_req_addr,
  input  logic              i_req_addr_fixed,
  input  logic [DATA_W-1:0] iv_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] ov_rsp_rdata,
  output logic              o_rsp_timeout,
  output logic              o_wr,
  output logic              o_rd,
  output logic [ADDR_W-1:0] ov_addr,
  output logic              o_addr_fixed,
  output logic [DATA_W-1:0] ov_wdata,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] iv_addr,
  input  logic              i_addr_fixed,
  input  logic [DATA_W-1:0] iv_rdata,
  output logic              o_stray
);

  logic [STATE_W-1:0] state, state_d;
  lbus_req_t          req_q, req_d;

  logic              wr_d, rd_d, addr_fixed_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              rsp_valid_d, rsp_timeout_d, stray_d;
  logic [DATA_W-1:0] rsp_rdata_d;

  logic ret_hit_c;
  logic tmo_clear_c, tmo_en_c, tmo_expire_c;

  assign ret_hit_c   = ret_match(i_wr, i_addr_fixed, iv_addr, req_q.addr);
  assign tmo_clear_c = (state != WAIT_RSP);
  assign tmo_en_c    = (state == WAIT_RSP) && !ret_hit_c;
  assign o_req_ready = (state == IDLE);

  cfg_lbus_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_tmo (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (tmo_clear_c),
    .en       (tmo_en_c),
    .expire_c (tmo_expire_c)
  );

  // Next state plus next value of every registered output; strobes and bus
  // fields are computed one cycle ahead so they sit on flops during ISSUE.
  always_comb begin
    state_d       = state;
    req_d         = req_q;
    wr_d          = 1'b0;
    rd_d          = 1'b0;
    addr_d        = '0;
    addr_fixed_d  = 1'b0;
    wdata_d       = '0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_timeout_d = 1'b0;
    stray_d       = i_wr && !((state == WAIT_RSP) && ret_hit_c);

    case (state)
      IDLE: begin
        if (i_req_valid) begin
          req_d.wr     = i_req_wr;
          req_d.addr   = iv_req_addr;
          req_d.fixed  = i_req_addr_fixed;
          req_d.wdata  = iv_req_wdata;
          wr_d         = i_req_wr;
          rd_d         = !i_req_wr;
          addr_d       = iv_req_addr;
          addr_fixed_d = i_req_addr_fixed;
          wdata_d      = iv_req_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (req_q.wr) begin
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d     = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A match on the expiry cycle still completes with data.
        if (ret_hit_c) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = iv_rdata;
          state_d     = DONE;
        end else if (tmo_expire_c) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      req_q         <= '0;
      o_wr          <= 1'b0;
      o_rd          <= 1'b0;
      ov_addr       <= '0;
      o_addr_fixed  <= 1'b0;
      ov_wdata      <= '0;
      o_rsp_valid   <= 1'b0;
      ov_rsp_rdata  <= '0;
      o_rsp_timeout <= 1'b0;
      o_stray       <= 1'b0;
    end else begin
      state         <= state_d;
      req_q         <= req_d;
      o_wr          <= wr_d;
      o_rd          <= rd_d;
      ov_addr       <= addr_d;
      o_addr_fixed  <= addr_fixed_d;
      ov_wdata      <= wdata_d;
      o_rsp_valid   <= rsp_valid_d;
      ov_rsp_rdata  <= rsp_rdata_d;
      o_rsp_timeout <= rsp_timeout_d;
      o_stray       <= stray_d;
    end
  end

endmodule
